// File: rtl/dfdd_result_packer.sv
// rtl/dfdd_result_packer.sv - confidence-masked depth result FIFO with frame markers and drop stats
module dfdd_result_packer #(
    parameter int EXP_WIDTH  = 8,
    parameter int FRAC_WIDTH = 23,
    parameter int FIFO_DEPTH = 16,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    localparam int FP_WIDTH  = 1 + EXP_WIDTH + FRAC_WIDTH
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [FP_WIDTH-1:0] z_i,
    input  logic [FP_WIDTH-1:0] c_i,
    input  logic [15:0]         col_i,
    input  logic [15:0]         row_i,
    input  logic                valid_i,
    input  logic [FP_WIDTH-1:0] c_thresh_i,
    input  logic                clear_stats_i,
    output logic [FP_WIDTH-1:0] z_o,
    output logic [FP_WIDTH-1:0] c_o,
    output logic                mask_o,
    output logic                sof_o,
    output logic                last_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [15:0]         drop_count_o,
    output logic                overflow_o,
    output logic                frame_done_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [FP_WIDTH-1:0] z;
        logic [FP_WIDTH-1:0] c;
        logic                mask;
        logic                sof;
        logic                last;
        logic                eof;
    } entry_t;

    typedef enum logic {IDLE, IN_FRAME} state_t;

    entry_t        mem [FIFO_DEPTH];
    entry_t        wr_entry;
    entry_t        head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          wr_en;
    logic          pop;
    logic          drop;
    state_t        state_q;
    state_t        state_d;
    logic          frame_done_d;
    logic          thresh_sign_unused;

    // The threshold is a magnitude; its sign bit carries no meaning.
    assign thresh_sign_unused = c_thresh_i[FP_WIDTH-1];

    always_comb begin
        wr_entry      = '0;
        wr_entry.mask = !c_i[FP_WIDTH-1] && (c_i[FP_WIDTH-2:0] >= c_thresh_i[FP_WIDTH-2:0]);
        wr_entry.z    = wr_entry.mask ? z_i : '0;
        wr_entry.c    = c_i;
        wr_entry.sof  = (col_i == 16'd0) && (row_i == 16'd0);
        wr_entry.last = (col_i == 16'(IMG_WIDTH - 1));
        wr_entry.eof  = wr_entry.last && (row_i == 16'(IMG_HEIGHT - 1));
    end

    // Fullness is judged at cycle start, so a same-cycle pop never frees a slot for the write.
    assign full    = (count == FULL_CNT);
    assign wr_en   = valid_i && !full;
    assign drop    = valid_i && full;
    assign valid_o = (count != '0);
    assign pop     = valid_o && ready_i;

    assign head   = mem[rd_ptr];
    assign z_o    = head.z;
    assign c_o    = head.c;
    assign mask_o = head.mask;
    assign sof_o  = head.sof;
    assign last_o = head.last;

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            drop_count_o <= '0;
            overflow_o   <= 1'b0;
        end else if (clear_stats_i) begin
            drop_count_o <= '0;
            overflow_o   <= 1'b0;
        end else if (drop) begin
            if (drop_count_o != 16'hFFFF) begin
                drop_count_o <= drop_count_o + 16'd1;
            end
            overflow_o <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            frame_done_o <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_done_o <= frame_done_d;
        end
    end

    // A frame closes only if it was opened; a repeated sof inside a frame restarts it silently.
    always_comb begin
        state_d      = state_q;
        frame_done_d = 1'b0;
        if (pop) begin
            case (state_q)
                IDLE: begin
                    if (head.sof) begin
                        state_d = IN_FRAME;
                    end
                end
                IN_FRAME: begin
                    if (head.eof) begin
                        state_d      = IDLE;
                        frame_done_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dfdd_result_packer.sv
// tb/tb_dfdd_result_packer.sv - randomized queue-model bench for dfdd_result_packer
module tb_dfdd_result_packer;

    localparam int DEPTH = 16;
    localparam int W     = 4;
    localparam int H     = 2;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] z_i, c_i, c_thresh_i;
    logic [15:0] col_i, row_i;
    logic        valid_i, clear_stats_i, ready_i;
    logic [31:0] z_o, c_o;
    logic        mask_o, sof_o, last_o, valid_o, overflow_o, frame_done_o;
    logic [15:0] drop_count_o;

    always #5 clk = ~clk;

    dfdd_result_packer #(
        .EXP_WIDTH(8), .FRAC_WIDTH(23), .FIFO_DEPTH(DEPTH), .IMG_WIDTH(W), .IMG_HEIGHT(H)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .z_i(z_i), .c_i(c_i), .col_i(col_i), .row_i(row_i),
        .valid_i(valid_i), .c_thresh_i(c_thresh_i), .clear_stats_i(clear_stats_i),
        .z_o(z_o), .c_o(c_o), .mask_o(mask_o), .sof_o(sof_o), .last_o(last_o),
        .valid_o(valid_o), .ready_i(ready_i), .drop_count_o(drop_count_o),
        .overflow_o(overflow_o), .frame_done_o(frame_done_o)
    );

    typedef struct {
        logic [31:0] z;
        logic [31:0] c;
        logic        mask, sof, last, eof;
    } ent_t;

    ent_t q[$];
    int   m_drops;
    bit   m_ovf, m_inframe, m_fd;
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("valid_o", {63'd0, valid_o}, {63'd0, q.size() != 0});
        if (q.size() != 0) begin
            chk("z_o", {32'd0, z_o}, {32'd0, q[0].z});
            chk("c_o", {32'd0, c_o}, {32'd0, q[0].c});
            chk("mask_o", {63'd0, mask_o}, {63'd0, q[0].mask});
            chk("sof_o", {63'd0, sof_o}, {63'd0, q[0].sof});
            chk("last_o", {63'd0, last_o}, {63'd0, q[0].last});
        end
        chk("drop_count_o", {48'd0, drop_count_o}, 64'(m_drops));
        chk("overflow_o", {63'd0, overflow_o}, {63'd0, m_ovf});
        chk("frame_done_o", {63'd0, frame_done_o}, {63'd0, m_fd});
    endtask

    // Called at a falling edge: drive one cycle of inputs, advance the model, check after the edge.
    task automatic cyc(input logic v, input logic [31:0] z, input logic [31:0] c,
                       input logic [31:0] th, input logic [15:0] col, input logic [15:0] row,
                       input logic rdy, input logic clr);
        ent_t e;
        bit   full, pop;
        valid_i = v; z_i = z; c_i = c; c_thresh_i = th; col_i = col; row_i = row;
        ready_i = rdy; clear_stats_i = clr;
        full   = (q.size() == DEPTH);
        pop    = (q.size() != 0) && rdy;
        e.mask = !c[31] && (c[30:0] >= th[30:0]);
        e.z    = e.mask ? z : 32'd0;
        e.c    = c;
        e.sof  = (col == 0) && (row == 0);
        e.last = (col == W - 1);
        e.eof  = e.last && (row == H - 1);
        m_fd   = 1'b0;
        if (pop) begin
            if (m_inframe && q[0].eof) begin
                m_inframe = 1'b0;
                m_fd      = 1'b1;
            end else if (q[0].sof) begin
                m_inframe = 1'b1;
            end
            void'(q.pop_front());
        end
        if (clr) begin
            m_drops = 0;
            m_ovf   = 1'b0;
        end else if (v && full) begin
            if (m_drops < 65535) m_drops++;
            m_ovf = 1'b1;
        end
        if (v && !full) q.push_back(e);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 32'd0, 32'd0, 32'd0, 16'd5, 16'd5, rdy, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        valid_i = 1'b0;
        rst_i   = 1'b1;
        #1;
        chk({tag, "_rst_valid"}, {63'd0, valid_o}, 64'd0);
        chk({tag, "_rst_drops"}, {48'd0, drop_count_o}, 64'd0);
        chk({tag, "_rst_ovf"}, {63'd0, overflow_o}, 64'd0);
        chk({tag, "_rst_fd"}, {63'd0, frame_done_o}, 64'd0);
        q.delete();
        m_drops = 0; m_ovf = 1'b0; m_inframe = 1'b0; m_fd = 1'b0;
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    initial begin
        int n, fdc, lastc;
        rst_i = 1'b1; valid_i = 1'b0; z_i = '0; c_i = '0; c_thresh_i = '0;
        col_i = '0; row_i = '0; ready_i = 1'b0; clear_stats_i = 1'b0;
        m_drops = 0; m_ovf = 1'b0; m_inframe = 1'b0; m_fd = 1'b0;
        repeat (2) @(negedge clk);
        do_reset("init");
        check_all();

        // Passing confidence, first pixel of frame, one-cycle latency.
        cyc(1'b1, 32'h40400000, 32'h3F000000, 32'h3E800000, 16'd0, 16'd0, 1'b1, 1'b0);
        chk("lit_valid", {63'd0, valid_o}, 64'd1);
        chk("lit_z", {32'd0, z_o}, 64'h40400000);
        chk("lit_mask", {63'd0, mask_o}, 64'd1);
        chk("lit_sof", {63'd0, sof_o}, 64'd1);
        idle(1'b1);

        // Negative confidence is masked even against a zero threshold.
        cyc(1'b1, 32'h12345678, 32'hBF800000, 32'h00000000, 16'd1, 16'd0, 1'b1, 1'b0);
        chk("neg_mask", {63'd0, mask_o}, 64'd0);
        chk("neg_z", {32'd0, z_o}, 64'd0);
        chk("neg_c", {32'd0, c_o}, 64'hBF800000);
        idle(1'b1);

        // Overfill: 20 writes into 16 slots, then drain in order.
        do_reset("ovf");
        for (int i = 0; i < 20; i++)
            cyc(1'b1, 32'(i + 1), 32'h3F800000, 32'd0, 16'd1, 16'd0, 1'b0, 1'b0);
        chk("ovf_drops", {48'd0, drop_count_o}, 64'd4);
        chk("ovf_flag", {63'd0, overflow_o}, 64'd1);
        for (int i = 0; i < 16; i++) begin
            chk("ovf_order", {32'd0, z_o}, 64'(i + 1));
            idle(1'b1);
        end
        chk("ovf_empty", {63'd0, valid_o}, 64'd0);

        // Full FIFO: same-cycle pop does not rescue the write.
        for (int i = 0; i < 16; i++)
            cyc(1'b1, 32'(i), 32'h3F800000, 32'd0, 16'd1, 16'd0, 1'b0, 1'b0);
        cyc(1'b1, 32'hDEAD, 32'h3F800000, 32'd0, 16'd1, 16'd0, 1'b1, 1'b0);
        chk("full_drops", {48'd0, drop_count_o}, 64'd5);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (valid_o) n++;
            idle(1'b1);
        end
        chk("full_occ15", 64'(n), 64'd15);

        // Clear wins over a same-cycle drop.
        for (int i = 0; i < 16; i++)
            cyc(1'b1, 32'(i), 32'h3F800000, 32'd0, 16'd1, 16'd0, 1'b0, 1'b0);
        cyc(1'b1, 32'hBEEF, 32'h3F800000, 32'd0, 16'd1, 16'd0, 1'b0, 1'b1);
        chk("clr_drops", {48'd0, drop_count_o}, 64'd0);
        chk("clr_ovf", {63'd0, overflow_o}, 64'd0);
        for (int i = 0; i < 17; i++) idle(1'b1);

        // Full 4x2 frame streamed.
        do_reset("frame");
        fdc = 0; lastc = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                cyc(1'b1, 32'(r * 16 + c), 32'h3F800000, 32'd0, 16'(c), 16'(r), 1'b1, 1'b0);
                if (valid_o && last_o) lastc++;
                if (frame_done_o) fdc++;
            end
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            if (frame_done_o) fdc++;
        end
        chk("frame_last_count", 64'(lastc), 64'd2);
        chk("frame_done_count", 64'(fdc), 64'd1);

        // Reset mid-frame with entries stored returns FSM to IDLE.
        do_reset("mid");
        cyc(1'b1, 32'd1, 32'h3F800000, 32'd0, 16'd0, 16'd0, 1'b1, 1'b0);
        idle(1'b1);
        for (int i = 0; i < 5; i++)
            cyc(1'b1, 32'(i), 32'h3F800000, 32'd0, 16'd1, 16'd0, 1'b0, 1'b0);
        do_reset("mid5");
        cyc(1'b1, 32'd7, 32'h3F800000, 32'd0, 16'(W - 1), 16'(H - 1), 1'b0, 1'b0);
        chk("post_rst_accept", {63'd0, valid_o}, 64'd1);
        idle(1'b1);
        idle(1'b1);
        chk("eof_idle_no_fd", {63'd0, frame_done_o}, 64'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 3) != 0,
                $urandom(),
                {1'($urandom_range(0, 1)), 31'($urandom())},
                {1'($urandom_range(0, 1)), 31'($urandom())},
                16'($urandom_range(0, W)), 16'($urandom_range(0, H)),
                $urandom_range(0, 4) < 3,
                $urandom_range(0, 40) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dfdd_result_packer.md
DFDD_RESULT_PACKER -- requirements
Module: dfdd_result_packer

Interface
REQ-001 SHALL have parameter EXP_WIDTH, default 8, floating-point exponent width.
REQ-002 SHALL have parameter FRAC_WIDTH, default 23, floating-point fraction width; FP_WIDTH = 1 + EXP_WIDTH + FRAC_WIDTH.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, power of two >= 4, number of entries.
REQ-004 SHALL have parameters IMG_WIDTH, default 640, and IMG_HEIGHT, default 480, frame size in pixels.
REQ-005 SHALL have ports: clk_i  in  1  the single clock; rst_i  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports: z_i  in  FP_WIDTH  depth estimate; c_i  in  FP_WIDTH  confidence; col_i  in  16  pixel column; row_i  in  16  pixel row; valid_i  in  1  input strobe (no backpressure).
REQ-007 SHALL have port c_thresh_i  in  FP_WIDTH  confidence threshold, sign bit ignored.
REQ-008 SHALL have port clear_stats_i  in  1  synchronous clear of drop_count_o and overflow_o.
REQ-009 SHALL have ports: z_o  out  FP_WIDTH; c_o  out  FP_WIDTH; mask_o  out  1  confidence pass; sof_o  out  1  first pixel of frame; last_o  out  1  last pixel of row; valid_o  out  1; ready_i  in  1.
REQ-010 SHALL have ports: drop_count_o  out  16  dropped inputs; overflow_o  out  1  sticky drop flag; frame_done_o  out  1  one-cycle pulse.

Function
REQ-011 mask SHALL be 1 iff c_i sign bit is 0 and c_i[FP_WIDTH-2:0] >= c_thresh_i[FP_WIDTH-2:0] (unsigned magnitude compare).
REQ-012 Stored z SHALL equal z_i when mask is 1, all-zeros when mask is 0; stored c SHALL always equal c_i.
REQ-013 sof SHALL be 1 iff col_i == 0 and row_i == 0; last SHALL be 1 iff col_i == IMG_WIDTH-1.
REQ-014 Each FIFO entry SHALL hold {z, c, mask, sof, last, eof}, eof = last and row_i == IMG_HEIGHT-1.
REQ-015 Write SHALL occur when valid_i is 1 and occupancy at cycle start < FIFO_DEPTH; a pop in the same cycle SHALL NOT rescue a write when full.
REQ-016 FIFO SHALL be first-word-fall-through: valid_o = (occupancy != 0); z_o/c_o/mask_o/sof_o/last_o reflect head entry.
REQ-017 Pop SHALL occur when valid_o and ready_i are both 1; head data SHALL be held stable while valid_o=1 and ready_i=0.
REQ-018 Simultaneous write and pop SHALL leave occupancy unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-019 Latency: entry written in cycle N SHALL appear on valid_o in cycle N+1 when FIFO was empty.
REQ-020 Throughput: one write and one pop per cycle sustained.
REQ-021 Dropped input (valid_i=1, full) SHALL increment drop_count_o, saturating at 0xFFFF, and set overflow_o.
REQ-022 clear_stats_i=1 SHALL zero drop_count_o and overflow_o next cycle; a drop in the same cycle SHALL be lost (clear wins).
REQ-023 Frame FSM states IDLE, IN_FRAME: IDLE->IN_FRAME on pop of sof entry; IN_FRAME->IDLE on pop of eof entry with frame_done_o=1 for that one cycle.
REQ-024 Pop of sof entry while IN_FRAME SHALL stay IN_FRAME (restart, no frame_done_o); pop of eof entry in IDLE SHALL NOT pulse frame_done_o.
REQ-025 Output data fields when valid_o=0 SHALL be don't-care except valid_o, frame_done_o, counters.

Reset
REQ-026 rst_i SHALL asynchronously clear pointers, occupancy, drop_count_o, overflow_o, frame_done_o; FSM to IDLE; valid_o=0.
REQ-027 Reset mid-operation SHALL discard all FIFO contents; first valid_i after rst_i deasserts SHALL be accepted.
REQ-028 FIFO storage array SHALL not require reset.

Verification
REQ-029 c_i=0x3F000000, c_thresh_i=0x3E800000, z_i=0x40400000, col=0,row=0, ready_i=1 -> next cycle valid_o=1, z_o=0x40400000, mask_o=1, sof_o=1.
REQ-030 c_i=0xBF800000 (negative), thresh 0x00000000 -> mask_o=0, z_o=0x00000000, c_o=0xBF800000.
REQ-031 ready_i=0, 20 consecutive valid_i (depth 16) -> 16 stored, drop_count_o=4, overflow_o=1; then ready_i=1 -> 16 pops in order.
REQ-032 Full FIFO, valid_i=1 and ready_i=1 same cycle -> input dropped, occupancy 15 after.
REQ-033 Stream full 4x2 frame (IMG_WIDTH=4, IMG_HEIGHT=2) -> last_o on cols 3, frame_done_o single pulse on pop of (3,1).
REQ-034 rst_i asserted with 5 entries stored -> valid_o=0 immediately, drop_count_o=0, FSM IDLE.
